serial_bit_feeder: RTL and testbench

//  Parallel-in/serial-out stage feeding the single-bit input of the downstream "101" sequence detector.

---
 rtl/serial_bit_feeder.sv | 76 +++++++
 tb/tb_serial_bit_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and
// drives it one bit per clock into the single-bit input of a "101" detector.
`timescale 1ns/1ps

module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_last,
  output logic [0:0]       fsm_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             at_last;
  logic             accept;

  // Handshake: a word moves when load_valid and load_ready are both high at a
  // posedge. load_ready comes from registers only, so a source may legally
  // wait for it before raising load_valid, or hold load_valid until it rises.
  assign at_last    = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign load_ready = (state == IDLE) || at_last;
  assign accept     = load_valid && load_ready;

  always_comb begin
    shift_next = shift_reg;
    if (MSB_FIRST) begin
      shift_next = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin
      shift_next = {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  // Accepting on the last-bit edge reloads directly, giving a gap-free stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      state     <= SHIFT;
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= shift_next;
      if (at_last) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign x_valid    = (state == SHIFT);
  assign x_out      = x_valid ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_BIT;
  assign frame_last = at_last;
  assign fsm_state  = state;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first and an LSB-first instance share one
// stimulus stream; a word-level model feeds expected-bit queues drained by a monitor.
`timescale 1ns/1ps

module tb_serial_bit_feeder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;

  logic       load_ready, x_out, x_valid, frame_last;
  logic [0:0] fsm_state;
  logic       lsb_load_ready, lsb_x_out, lsb_x_valid, lsb_frame_last;
  logic [0:0] lsb_fsm_state;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid),
    .frame_last(frame_last), .fsm_state(fsm_state)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lsb_load_ready), .x_out(lsb_x_out), .x_valid(lsb_x_valid),
    .frame_last(lsb_frame_last), .fsm_state(lsb_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;

  // Entries are {bit, is_last}; one queue per bit order.
  logic [1:0] exp_q[$];
  logic [1:0] lsb_q[$];
  bit         exp_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word accepted at an edge becomes W scheduled bits.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      lsb_q.delete();
      exp_ready = 1'b1;
    end else if (load_valid && exp_ready) begin
      for (int i = 0; i < W; i++) begin
        exp_q.push_back({load_data[W-1-i], (i == W-1) ? 1'b1 : 1'b0});
        lsb_q.push_back({load_data[i],     (i == W-1) ? 1'b1 : 1'b0});
      end
    end
  end

  // Monitor: each cycle either the next scheduled bit or the idle pattern.
  always @(negedge clk) begin
    if (!reset) begin
      logic [1:0] e;
      int n;
      n = exp_q.size();
      check("load_ready", {31'd0, load_ready}, {31'd0, (n <= 1)});
      check("lsb_load_ready", {31'd0, lsb_load_ready}, {31'd0, (lsb_q.size() <= 1)});
      exp_ready = (n <= 1);
      if (n > 0) begin
        e = exp_q.pop_front();
        check("x_valid", {31'd0, x_valid}, 32'd1);
        check("x_out", {31'd0, x_out}, {31'd0, e[1]});
        check("frame_last", {31'd0, frame_last}, {31'd0, e[0]});
      end else begin
        check("idle_x_valid", {31'd0, x_valid}, 32'd0);
        check("idle_x_out", {31'd0, x_out}, 32'd0);
        check("idle_frame_last", {31'd0, frame_last}, 32'd0);
      end
      if (lsb_q.size() > 0) begin
        e = lsb_q.pop_front();
        check("lsb_x_valid", {31'd0, lsb_x_valid}, 32'd1);
        check("lsb_x_out", {31'd0, lsb_x_out}, {31'd0, e[1]});
        check("lsb_frame_last", {31'd0, lsb_frame_last}, {31'd0, e[0]});
      end else begin
        check("lsb_idle_x_valid", {31'd0, lsb_x_valid}, 32'd0);
        check("lsb_idle_x_out", {31'd0, lsb_x_out}, 32'd0);
      end
    end
  end

  // ---------------- downstream "101" detector model ----------------
  logic       det_clr = 1'b0;
  logic [2:0] hist;
  logic       det_out;
  always @(posedge clk) begin
    if (det_clr) hist <= 3'b000;
    else         hist <= {hist[1:0], x_out};
  end
  assign det_out = (hist == 3'b101);

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      if (exp_ready) done = 1'b1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits, first_hit, second_hit;

    repeat (2) @(posedge clk);
    #1;
    check("rst_x_valid", {31'd0, x_valid}, 32'd0);
    check("rst_x_out", {31'd0, x_out}, 32'd0);
    check("rst_frame_last", {31'd0, frame_last}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single word, then a back-to-back pair.
    send_word(8'hA5);
    wait_idle();
    send_word(8'hA5);
    send_word(8'h3C);
    wait_idle();

    // LSB-first instance sees 1 then seven 0s.
    send_word(8'h01);
    wait_idle();

    // One-cycle pulse mid-frame must be ignored.
    send_word(8'hA5);
    repeat (2) @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    send_word(8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_x_valid", {31'd0, x_valid}, 32'd0);
    check("async_x_out", {31'd0, x_out}, 32'd0);
    check("async_load_ready", {31'd0, load_ready}, 32'd1);
    check("async_frame_last", {31'd0, frame_last}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_word(8'h81);
    wait_idle();

    // Chain into the detector.
    det_clr = 1'b1;
    @(posedge clk);
    #1;
    det_clr = 1'b0;
    hits = 0;
    first_hit = 0;
    second_hit = 0;
    send_word(8'hB4);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (det_out) begin
        hits++;
        if (hits == 1) first_hit = c;
        if (hits == 2) second_hit = c;
      end
    end
    check("det_hits", hits, 32'd2);
    check("det_first_cycle", first_hit, 32'd4);
    check("det_second_cycle", second_hit, 32'd7);
    wait_idle();

    // Random words with random gaps, including zero-gap runs.
    for (int k = 0; k < 40; k++) begin
      send_word(W'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    check("queue_drained", exp_q.size(), 32'd0);
    check("lsb_queue_drained", lsb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
